// File: rtl/medidor_de_frecuencia.sv
// medidor_de_frecuencia: counts rising edges of an asynchronous input over a W-cycle gate window.
// Optional FM_SINGLE_SHOT_EN: report one window, then hold until en is cycled low and high.
module medidor_de_frecuencia #(
    parameter int unsigned in_f   = 32'd75000000,
    parameter int unsigned gate_f = 32'd1,
    parameter int          cnt_w  = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    output logic [cnt_w-1:0] freq,
    output logic             valid,
    output logic             ovf
);
    localparam longint unsigned W = 64'(in_f / gate_f);
    localparam int win_w = (W > 64'd1) ? $clog2(W) : 1;
    localparam logic [win_w-1:0] W_LAST = win_w'(W - 64'd1);
    localparam logic [cnt_w-1:0] CNT_MAX = {cnt_w{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               sync1_r;
    logic               sync2_r;
    logic               prev_r;
    logic               edge_s;
    logic [win_w-1:0]   win_cnt_r;
    logic [win_w-1:0]   win_nxt_s;
    logic [cnt_w-1:0]   edge_cnt_r;
    logic [cnt_w-1:0]   cnt_nxt_s;
    logic [cnt_w-1:0]   cnt_upd_s;
    logic               sticky_r;
    logic               sticky_nxt_s;
    logic               sticky_upd_s;
    logic               load_s;

    // Two-flop synchronizer plus a delay flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign edge_s = sync2_r & ~prev_r;

    // Edge count including this cycle's edge, saturating into the sticky overflow bit
    always_comb begin
        cnt_upd_s    = edge_cnt_r;
        sticky_upd_s = sticky_r;
        if (edge_s) begin
            if (edge_cnt_r == CNT_MAX) begin
                sticky_upd_s = 1'b1;
            end else begin
                cnt_upd_s = edge_cnt_r + cnt_w'(1);
            end
        end else begin
            cnt_upd_s    = edge_cnt_r;
            sticky_upd_s = sticky_r;
        end
    end

    // Next-state logic; the terminal cycle reloads the counters so windows abut with no gap
    always_comb begin
        state_nxt_s  = state_r;
        win_nxt_s    = '0;
        cnt_nxt_s    = '0;
        sticky_nxt_s = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_nxt_s = MEASURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MEASURE: begin
                if (!en) begin
                    state_nxt_s = IDLE;
                end else if (win_cnt_r == W_LAST) begin
                    load_s = 1'b1;
`ifdef FM_SINGLE_SHOT_EN
                    state_nxt_s = DONE;
`else
                    state_nxt_s = MEASURE;
`endif
                end else begin
                    state_nxt_s  = MEASURE;
                    win_nxt_s    = win_cnt_r + win_w'(1);
                    cnt_nxt_s    = cnt_upd_s;
                    sticky_nxt_s = sticky_upd_s;
                end
            end
            DONE: begin
                if (en) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            win_cnt_r  <= '0;
            edge_cnt_r <= '0;
            sticky_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            win_cnt_r  <= win_nxt_s;
            edge_cnt_r <= cnt_nxt_s;
            sticky_r   <= sticky_nxt_s;
        end
    end

    // Result registers: freq/ovf move only together with the valid strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq  <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= load_s;
            if (load_s) begin
                freq <= cnt_upd_s;
                ovf  <= sticky_upd_s;
            end else begin
                freq <= freq;
                ovf  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_medidor_de_frecuencia.sv
// Scoreboard bench for medidor_de_frecuencia: W=100 cycles, a 27-bit and a 4-bit counter instance
// share one stimulus; expected window results are queued on stimulus and popped on each valid.
module tb_medidor_de_frecuencia;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sig_in = 1'b0;
    logic        en = 1'b0;
    logic [26:0] freq;
    logic        valid;
    logic        ovf;
    logic [3:0]  freq_s;
    logic        valid_s;
    logic        ovf_s;

    typedef struct {
        bit     care;
        longint f27;
        longint f4;
        bit     o4;
        int     gap;
    } exp_t;

    exp_t sb[$];
    exp_t item;
    int   check_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   last_valid_cyc = 0;
    int   period = 0;
    int   ph = 0;
    int   m = 0;
    int   n0 = 0;

    medidor_de_frecuencia #(.in_f(32'd100), .gate_f(32'd1), .cnt_w(27)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
        .freq(freq), .valid(valid), .ovf(ovf)
    );

    medidor_de_frecuencia #(.in_f(32'd100), .gate_f(32'd1), .cnt_w(4)) dut_s (
        .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
        .freq(freq_s), .valid(valid_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input longint got, input longint exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // square-wave source, changes 3 time units after a clock edge
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (period == 0) begin
                sig_in = 1'b0;
                ph = 0;
            end else begin
                if (ph >= period - 1) ph = 0;
                else ph = ph + 1;
                sig_in = (ph < period / 2);
            end
        end
    end

    // scoreboard consumer
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt = valid_cnt + 1;
            check_value("valid_pair", valid_s, 1);
            if (sb.size() == 0) begin
                check_value("unexpected_valid", 1, 0);
            end else begin
                item = sb.pop_front();
                if (item.gap != 0) check_value("valid_gap", cyc - last_valid_cyc, item.gap);
                if (item.care) begin
                    check_value("freq27", freq, item.f27);
                    check_value("ovf27", ovf, 0);
                    check_value("freq4", freq_s, item.f4);
                    check_value("ovf4", ovf_s, item.o4);
                end
            end
            last_valid_cyc = cyc;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input bit care, input int f, input int gap);
        exp_t e;
        e.care = care;
        e.f27  = f;
        e.f4   = (f > 15) ? 15 : f;
        e.o4   = (f > 15);
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic wait_valids(input int target);
        int budget;
        budget = 110 * (target - valid_cnt) + 20;
        for (int i = 0; i < budget && valid_cnt < target; i++) step();
        if (valid_cnt < target) check_value("valid_timeout", valid_cnt, target);
    endtask

    initial begin
        #2 rst = 1'b1;
        step();
        check_value("rst_freq", freq, 0);
        check_value("rst_valid", valid, 0);
        check_value("rst_ovf", ovf, 0);
        check_value("rst_freq4", freq_s, 0);
        period = 10;
        step();
        rst = 1'b0;
        repeat (20) step();
        m = cyc;
        en = 1'b1;
        push_exp(1'b1, 10, 0);
`ifdef FM_SINGLE_SHOT_EN
        wait_valids(1);
        check_value("entry_latency", last_valid_cyc - m, 101);
        repeat (500) step();
        check_value("single_shot_hold", valid_cnt, 1);
        check_value("single_shot_freq", freq, 10);
        en = 1'b0;
        step();
        m = cyc;
        en = 1'b1;
        push_exp(1'b1, 10, 0);
        wait_valids(2);
        check_value("rearm_latency", last_valid_cyc - m, 101);
        repeat (300) step();
        check_value("rearm_count", valid_cnt, 2);
`else
        push_exp(1'b1, 10, 100);
        push_exp(1'b1, 10, 100);
        wait_valids(1);
        check_value("entry_latency", last_valid_cyc - m, 101);
        wait_valids(3);
        // input held low
        period = 0;
        push_exp(1'b0, 0, 100);
        push_exp(1'b1, 0, 100);
        push_exp(1'b1, 0, 100);
        wait_valids(6);
        // period 4: 25 edges saturate the 4-bit instance
        period = 4;
        push_exp(1'b0, 0, 100);
        push_exp(1'b1, 25, 100);
        push_exp(1'b1, 25, 100);
        wait_valids(9);
        period = 10;
        push_exp(1'b0, 0, 100);
        push_exp(1'b1, 10, 100);
        push_exp(1'b1, 10, 100);
        wait_valids(12);
        // en dropped mid-window: partial window discarded
        repeat (50) step();
        en = 1'b0;
        n0 = valid_cnt;
        repeat (60) step();
        check_value("no_valid_after_drop", valid_cnt, n0);
        check_value("freq_held", freq, 10);
        check_value("freq4_held", freq_s, 10);
        check_value("ovf4_held", ovf_s, 0);
        push_exp(1'b1, 10, 0);
        m = cyc;
        en = 1'b1;
        wait_valids(13);
        check_value("reenable_latency", last_valid_cyc - m, 101);
        // asynchronous reset between clock edges
        repeat (40) step();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_value("arst_freq", freq, 0);
        check_value("arst_valid", valid, 0);
        check_value("arst_ovf", ovf, 0);
        check_value("arst_freq4", freq_s, 0);
        repeat (2) step();
        push_exp(1'b0, 0, 0);
        push_exp(1'b1, 10, 100);
        m = cyc;
        rst = 1'b0;
        wait_valids(14);
        check_value("post_reset_latency", last_valid_cyc - m, 101);
        wait_valids(15);
`endif
        check_value("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
